// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared arbiter FSM state type and width constants.
package wb_port_arbiter_pkg;
   localparam int REG_IDX_W = 5;
   localparam int CNT_W     = 16;
   typedef enum logic [1:0] {IDLE, WAIT, STARVED} arb_state_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback-stage, MDU valid/ready, register-file write port and status bundle.
interface wb_port_arbiter_if
   import wb_port_arbiter_pkg::*;
   #(parameter int DATA_WIDTH = 32);
   logic                  reg_write_w;
   logic [REG_IDX_W-1:0]  rd_w;
   logic [DATA_WIDTH-1:0] result_w;
   logic                  mdu_valid;
   logic [REG_IDX_W-1:0]  mdu_rd;
   logic [DATA_WIDTH-1:0] mdu_result;
   logic                  mdu_ready;
   logic                  rf_we;
   logic [REG_IDX_W-1:0]  rf_rd;
   logic [DATA_WIDTH-1:0] rf_wdata;
   logic                  stall_req;
   logic                  mdu_pending;
   modport master (
      output reg_write_w, rd_w, result_w, mdu_valid, mdu_rd, mdu_result,
      input  mdu_ready, rf_we, rf_rd, rf_wdata, stall_req, mdu_pending
   );
   modport slave (
      input  reg_write_w, rd_w, result_w, mdu_valid, mdu_rd, mdu_result,
      output mdu_ready, rf_we, rf_rd, rf_wdata, stall_req, mdu_pending
   );
endinterface

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: power-of-two circular buffer for MDU results; storage is not reset.
module wb_result_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic [AW:0]      o_count
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (i_pop) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_wdata;
   end
   assign o_rdata = r_mem[r_rptr];
   assign o_count = r_count;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the writeback stage and buffered MDU results.
// Optional macro WB_ARB_PERF_EN adds the saturating perf_conflicts counter output.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic clk,
   input logic rst_n,
   wb_port_arbiter_if.slave bus
`ifdef WB_ARB_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_conflicts
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = REG_IDX_W + DATA_WIDTH;
   arb_state_e            r_state;
   arb_state_e            w_state_nxt;
   logic [CNT_W-1:0]      r_starve;
   logic [CNT_W-1:0]      w_starve_nxt;
   logic [AW:0]           w_count;
   logic [EW-1:0]         w_head;
   logic [REG_IDX_W-1:0]  w_head_rd;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic                  w_pipe_own;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_drain;
   wb_result_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata ({bus.mdu_rd, bus.mdu_result}),
      .o_rdata (w_head),
      .o_count (w_count)
   );
   assign {w_head_rd, w_head_data} = w_head;
   assign w_pipe_own = bus.reg_write_w && (bus.rd_w != '0);
   assign w_empty    = (w_count == '0);
   assign w_pop      = !w_pipe_own && !w_empty;
   // ready comes from the registered count only, so a pop never unblocks a full buffer in the same cycle
   assign bus.mdu_ready = (w_count < (AW+1)'(FIFO_DEPTH));
   assign w_push        = bus.mdu_valid && bus.mdu_ready;
   assign w_drain       = w_pop && !w_push && (w_count == (AW+1)'(1));
   assign bus.rf_we       = w_pipe_own || (w_pop && (w_head_rd != '0));
   assign bus.rf_rd       = w_pipe_own ? bus.rd_w : w_pop ? w_head_rd : '0;
   assign bus.rf_wdata    = w_pipe_own ? bus.result_w : w_pop ? w_head_data : '0;
   assign bus.stall_req   = (r_state == STARVED);
   assign bus.mdu_pending = !w_empty;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_starve <= w_starve_nxt;
      end
   end
   // the stall is raised so that it is visible on the STARVE_LIMIT-th consecutive blocked cycle
   always_comb begin
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve;
      case (r_state)
         IDLE: begin
            w_starve_nxt = '0;
            if (w_push && !w_pop) w_state_nxt = WAIT;
         end
         WAIT: begin
            if (w_pop) begin
               w_starve_nxt = '0;
               if (w_drain) w_state_nxt = IDLE;
            end else if (!w_empty) begin
               w_starve_nxt = r_starve + 1'b1;
               if (int'(r_starve) + 1 >= STARVE_LIMIT - 1) w_state_nxt = STARVED;
            end
         end
         STARVED: begin
            if (w_pop) begin
               w_starve_nxt = '0;
               w_state_nxt  = w_drain ? IDLE : WAIT;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end
`ifdef WB_ARB_PERF_EN
   logic [CNT_W-1:0] r_perf;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_perf <= '0;
      else if (w_pipe_own && !w_empty && (r_perf != '1)) r_perf <= r_perf + 1'b1;
   end
   assign perf_conflicts = r_perf;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and randomized scoreboard bench for wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;
   localparam int DW    = 32;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;
   logic clk;
   logic rst_n;
   wb_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();
`ifdef WB_ARB_PERF_EN
   logic [15:0] perf;
   int perf_exp;
`endif
   wb_port_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef WB_ARB_PERF_EN
      ,
      .perf_conflicts (perf)
`endif
   );
   int   checks;
   int   errors;
   int   blk;
   bit   last_acc;
   ent_t mq[$];
   ent_t exp_q[$];
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic drive_idle();
      bus.reg_write_w = 1'b0;
      bus.rd_w        = '0;
      bus.result_w    = '0;
      bus.mdu_valid   = 1'b0;
      bus.mdu_rd      = '0;
      bus.mdu_result  = '0;
   endtask
   // one clock of stimulus; the model decides who owns the port from the buffered queue alone
   task automatic step(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mres);
      bit own;
      bit pop;
      bit rdy;
      bit we;
      logic [4:0]  e_rd;
      logic [31:0] e_wd;
      @(negedge clk);
      bus.reg_write_w = rw;
      bus.rd_w        = rd;
      bus.result_w    = res;
      bus.mdu_valid   = mv;
      bus.mdu_rd      = mrd;
      bus.mdu_result  = mres;
      #1;
      own  = rw && (rd != 0);
      pop  = !own && (mq.size() > 0);
      rdy  = mq.size() < DEPTH;
      we   = own || (pop && mq[0].rd != 0);
      e_rd = own ? rd : pop ? mq[0].rd : 5'd0;
      e_wd = own ? res : pop ? mq[0].data : 32'd0;
      chk("mdu_ready", 32'(bus.mdu_ready), 32'(rdy));
      chk("mdu_pending", 32'(bus.mdu_pending), 32'(mq.size() != 0));
      chk("stall_req", 32'(bus.stall_req), 32'(blk >= LIMIT - 1));
      chk("rf_we", 32'(bus.rf_we), 32'(we));
      chk("rf_rd", 32'(bus.rf_rd), 32'(e_rd));
      chk("rf_wdata", bus.rf_wdata, e_wd);
      if (we) exp_q.push_back('{rd: e_rd, data: e_wd});
`ifdef WB_ARB_PERF_EN
      if (own && mq.size() > 0 && perf_exp < 16'hFFFF) perf_exp++;
`endif
      if (pop) begin
         void'(mq.pop_front());
         blk = 0;
      end else if (mq.size() > 0) begin
         blk++;
      end
      last_acc = mv && rdy;
      if (last_acc) mq.push_back('{rd: mrd, data: mres});
   endtask
   task automatic async_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_stall_req", 32'(bus.stall_req), 32'd0);
      chk("rst_mdu_pending", 32'(bus.mdu_pending), 32'd0);
      chk("rst_mdu_ready", 32'(bus.mdu_ready), 32'd1);
      drive_idle();
      mq.delete();
      blk = 0;
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
   endtask
   // scoreboard monitor: every write the DUT presents must match the oldest expected write
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         #2;
         if (bus.rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got write rd=%0d data=%0h required none", bus.rf_rd, bus.rf_wdata);
            end else begin
               e = exp_q.pop_front();
               chk("sb_rd", 32'(bus.rf_rd), 32'(e.rd));
               chk("sb_wdata", bus.rf_wdata, e.data);
            end
         end
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int  bias;
      bit  hold;
      logic        rw, mv;
      logic [4:0]  rd, mrd;
      logic [31:0] mres;
      checks = 0;
      errors = 0;
      blk    = 0;
`ifdef WB_ARB_PERF_EN
      perf_exp = 0;
`endif
      rst_n = 1'b0;
      drive_idle();
      #12;
      chk("reset_mdu_ready", 32'(bus.mdu_ready), 32'd1);
      chk("reset_mdu_pending", 32'(bus.mdu_pending), 32'd0);
      chk("reset_stall_req", 32'(bus.stall_req), 32'd0);
      chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      // single MDU result through an idle port
      step(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // pipeline rd=3 starves one MDU entry
      step(1, 5'd3, 32'h1111, 1, 5'd7, 32'hCAFE0007);
      repeat (5) step(1, 5'd3, $urandom, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // buffer fills while blocked; third result is held until space opens
      step(1, 5'd4, 32'h2, 1, 5'd8, 32'hA8);
      step(1, 5'd4, 32'h3, 1, 5'd9, 32'hA9);
      step(1, 5'd4, 32'h4, 1, 5'd10, 32'hAA);
      step(1, 5'd4, 32'h5, 1, 5'd10, 32'hAA);
      step(0, 0, 0, 1, 5'd10, 32'hAA);
      step(0, 0, 0, 1, 5'd10, 32'hAA);
      repeat (3) step(0, 0, 0, 0, 0, 0);
      // rd=0 result is discarded
      step(0, 0, 0, 1, 5'd0, 32'h5A5A5A5A);
      repeat (2) step(0, 0, 0, 0, 0, 0);
      // pipeline write to x0 does not own the port
      step(1, 5'd6, 32'h66, 1, 5'd11, 32'hB11);
      step(1, 5'd0, 32'h77, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // two entries buffered and starved, then an asynchronous reset
      step(1, 5'd12, 32'hC1, 1, 5'd13, 32'hD13);
      step(1, 5'd12, 32'hC2, 1, 5'd14, 32'hD14);
      repeat (5) step(1, 5'd12, $urandom, 0, 0, 0);
      async_reset();
      step(0, 0, 0, 1, 5'd15, 32'hF00D);
      repeat (2) step(0, 0, 0, 0, 0, 0);
      // randomized traffic with varying pipeline pressure and held MDU requests
      hold = 0;
      bias = 50;
      mv = 0;
      mrd = 0;
      mres = 0;
      for (int c = 0; c < 1500; c++) begin
         if (c % 100 == 0) bias = (c / 100) % 3 == 0 ? 20 : (c / 100) % 3 == 1 ? 60 : 95;
         if (!hold) begin
            mv   = 1'($urandom_range(0, 1));
            mrd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mres = $urandom;
         end
         rw = 1'($urandom_range(0, 99) < bias);
         rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         step(rw, rd, $urandom, mv, mrd, mres);
         hold = mv && !last_acc;
      end
      repeat (DEPTH + 3) step(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #3;
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
`ifdef WB_ARB_PERF_EN
      chk("perf_conflicts", 32'(perf), 32'(perf_exp));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of all result data paths.
REQ-002 Parameter FIFO_DEPTH, default 2: number of entries in the secondary-result buffer (power of two, at least 2).
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive lost-arbitration cycles before a stall request is raised.
REQ-004 Ports: clk in 1, single clock; rst_n in 1, reset, asynchronous and active-low.
REQ-005 Pipeline writeback ports: reg_write_w in 1, rd_w in 5, result_w in DATA_WIDTH, all from the writeback stage.
REQ-006 Multi-cycle unit (MDU) ports: mdu_valid in 1, mdu_rd in 5, mdu_result in DATA_WIDTH, mdu_ready out 1; together these form a valid/ready handshake.
REQ-007 Register-file write port outputs: rf_we out 1, rf_rd out 5, rf_wdata out DATA_WIDTH.
REQ-008 Status outputs: stall_req out 1 (request to hazard unit for a writeback bubble); mdu_pending out 1 (buffer non-empty).

Function
REQ-009 An MDU transfer SHALL occur on a rising clk edge with mdu_valid=1 and mdu_ready=1, pushing {mdu_rd, mdu_result} into the FIFO.
REQ-010 mdu_ready SHALL be 1 iff the registered FIFO count is less than FIFO_DEPTH; a same-cycle pop SHALL NOT raise ready when the FIFO is full.
REQ-011 No MDU result SHALL bypass the FIFO; the minimum push-to-write latency is 1 cycle.
REQ-012 The pipeline SHALL own the port when reg_write_w=1 and rd_w!=0: rf_we=1, rf_rd=rd_w, rf_wdata=result_w, combinationally.
REQ-013 When the pipeline does not own the port and the FIFO is non-empty, the head SHALL be popped that cycle; rf_we=(head rd!=0), rf_rd=head rd, rf_wdata=head data.
REQ-014 A head entry with rd=0 SHALL be popped and discarded without asserting rf_we.
REQ-015 When neither source drives the port, rf_we=0, rf_rd=0, rf_wdata=0.
REQ-016 Simultaneous push and pop SHALL leave the count unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-017 FSM states: IDLE (FIFO empty), WAIT (non-empty, head blocked), STARVED.
REQ-018 IDLE->WAIT on push without pop; WAIT->IDLE when the count reaches 0; WAIT increments starve_cnt on each cycle the head is blocked and clears it on any pop.
REQ-019 WAIT->STARVED when starve_cnt reaches STARVE_LIMIT-1 while blocked; stall_req=1 only in STARVED.
REQ-020 STARVED->WAIT (count>0) or STARVED->IDLE (count=0) on the first pop; if the pipeline still owns the port, the state SHALL remain STARVED with the pipeline write honoured.
REQ-021 mdu_pending SHALL equal (count!=0).

Reset
REQ-022 Asserting rst_n=0 SHALL immediately clear the pointers, the count, starve_cnt and the state (to IDLE), and set stall_req=0, mdu_pending=0 and mdu_ready=1; buffered entries SHALL be lost.
REQ-023 FIFO data storage SHALL NOT be reset.
REQ-024 Deassertion SHALL be honoured asynchronously; a handshake in the first post-reset edge SHALL be accepted.

Configuration
REQ-025 With macro WB_ARB_PERF_EN defined: output perf_conflicts, 16 bits, SHALL count cycles where the pipeline owns the port while the FIFO is non-empty; it saturates at 0xFFFF and is reset to 0.
REQ-026 Without WB_ARB_PERF_EN, the perf_conflicts port and its counter SHALL be absent.

Structure
REQ-027 The shared package SHALL hold the FSM state enum (IDLE, WAIT, STARVED), the register-index width constant (5) and the counter width constant (16).
REQ-028 One sub-module, wb_result_fifo (push/pop/count, parameterised on width and depth), SHALL be instantiated.

Verification
REQ-029 Case 1: MDU push {rd=5, 0xDEADBEEF} with the pipeline idle -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF, and mdu_pending falls.
REQ-030 Case 2: Pipeline rd=3 writing every cycle plus one MDU push, with STARVE_LIMIT=4 -> stall_req=1 on the 4th blocked cycle; when the pipeline drops, the MDU entry is written and stall_req=0 the next cycle.
REQ-031 Case 3: Two MDU pushes while blocked -> mdu_ready=0; a third mdu_valid is held without loss; after one pop, ready=1 the following cycle.
REQ-032 Case 4: MDU push with rd=0 -> popped, rf_we stays 0, and the count returns to 0.
REQ-033 Case 5: Pipeline write with rd_w=0 concurrent with a non-empty FIFO -> the MDU head is written that cycle.
REQ-034 Case 6: rst_n pulsed low with 2 entries buffered in STARVED -> all status outputs clear immediately, mdu_ready=1, and no stale write occurs after release.
